dbg_vjtag_initiator: RTL
========================

Name: dbg_vjtag_initiator

Overview:
- Host-side master for the CPU debug slave's virtual-JTAG port. It is the initiator end of the link whose responder is the debug slave TCK/sysclk pair.
- Runs on the system clock. Generates a divided TCK and drives the virtual-state strobes, the IR value and TDI. Captures TDO.
- Accepts one {IR, DR} command at a time and returns the DR value shifted out of the slave.
- Used by simulation benches and the on-chip self-test path in place of the Quartus virtual JTAG hub.

Parameters:
- DR_WIDTH, 38, data-register length in bits (matches the slave shift register).
- IR_WIDTH, 2, virtual instruction register width.
- TCK_DIV, 2, TCK half-period in clk cycles (minimum 1).
- RTI_CYCLES, 1, TCK periods spent in run-test-idle after update (minimum 1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  initiator idle and able to accept a command
- cmd_ir  in  IR_WIDTH  instruction to load
- cmd_dr  in  DR_WIDTH  data to shift in, LSB first
- rsp_valid  out  1  captured data available
- rsp_ready  in  1  consumer accepts the response
- rsp_dr  out  DR_WIDTH  data shifted out of the slave; bit i is TDO sampled in shift i
- vji_tck  out  1  generated TCK
- vji_tdi  out  1  serial data to the slave
- vji_tdo  in  1  serial data from the slave
- vji_ir_in  out  IR_WIDTH  IR value presented to the slave
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state strobes

Behaviour:
- Reset values while reset is high: state IDLE; vji_tck=0, vji_tdi=0, vji_ir_in=0; all strobes 0; rsp_valid=0; rsp_dr=0; cmd_ready=1 (cmd_ready = state==IDLE).
- Reset taken mid-command aborts the command immediately. No response is produced.
- TCK timing:
  - One TCK period = 2*TCK_DIV clk cycles: a low phase of TCK_DIV cycles, then a high phase of TCK_DIV cycles.
  - TCK toggles only outside IDLE and RESP. It is held 0 in IDLE and RESP.
  - Strobes, vji_tdi and vji_ir_in change only at the start of a period (falling edge).
  - vji_tdo is sampled on the last clk cycle of the high phase.
- Command handshake: accepted on a clk edge with cmd_valid && cmd_ready. cmd_ir and cmd_dr are latched on that edge.
- Response handshake: rsp_valid rises when RTI completes and holds, with rsp_dr stable, until rsp_valid && rsp_ready. The state then returns to IDLE.
- Only one command is outstanding at a time.
- FSM (each state lasts whole TCK periods):
  - IDLE -> UIR on accept.
  - UIR: 1 period; vji_uir=1; vji_ir_in = latched IR (vji_ir_in then holds until the next UIR).
  - CDR: 1 period; vji_cdr=1.
  - SDR: DR_WIDTH periods; vji_sdr=1; vji_tdi = shift bit k in period k; the TDO sample is stored at bit k. A 6-bit counter (sized clog2(DR_WIDTH)) ends the state at DR_WIDTH-1.
  - UDR: 1 period; vji_udr=1.
  - RTI: RTI_CYCLES periods; vji_rti=1.
  - RESP: waits for rsp_ready.
- Latency with defaults: (1+1+38+1+1)*4 = 168 clk cycles from the accepting edge to rsp_valid=1.
- rsp_valid and rsp_ready high together on the first RESP cycle: the response completes and cmd_ready returns 1 on the next cycle. There is no back-to-back bypass.
- cmd_valid is ignored in every state except IDLE.
- Exactly one strobe is high in any non-IDLE/RESP cycle.

Optional Feature:
- Macro: DBG_VJTAG_IR_CACHE_EN.
- Defined:
  - A cached last-IR register plus a valid bit, both cleared by reset.
  - If cmd_ir equals the cached value and the cache is valid, UIR is skipped (IDLE -> CDR). Latency with defaults becomes 164 cycles.
- Undefined: UIR is always executed. No cache register exists.

Decomposition:
- Package dbg_vjtag_pkg holds:
  - the state enum (IDLE, UIR, CDR, SDR, UDR, RTI, RESP);
  - default width constants DBG_DR_WIDTH=38 and DBG_IR_WIDTH=2;
  - IR encoding constants for the slave: 0 = OCIMEM, 1 = TRACEMEM, 2 = BREAK, 3 = TRACECTRL.
- One sub-module, dbg_vjtag_tck_gen: produces vji_tck, a period-start pulse and a sample pulse from TCK_DIV. It is enabled by the FSM.

Test Plan:
- Loopback (vji_tdo = vji_tdi delayed by one TCK period), cmd_ir=2, cmd_dr=38'h2A_5555_AAAA -> rsp_dr = cmd_dr shifted by one bit with bit0 = 0. rsp_valid arrives 168 cycles after accept.
- vji_tdo tied 1, any cmd_dr -> rsp_dr = all ones. Checker confirms vji_sdr high for exactly 38 TCK periods and vji_ir_in=2 from UIR onward.
- rsp_ready held low for 20 cycles -> rsp_valid and rsp_dr remain stable; cmd_ready stays 0; a cmd_valid pulse is ignored.
- Reset asserted during SDR shift 17 -> all outputs return to reset values in the same cycle; the next command completes normally.
- TCK_DIV=1, RTI_CYCLES=3 -> TCK period of 2 cycles; vji_rti high for 6 cycles; latency (1+1+38+1+3)*2 = 88 cycles.
- With DBG_VJTAG_IR_CACHE_EN defined, two commands with ir=1 -> the second shows no vji_uir pulse and has latency 164. A third command with ir=3 shows a vji_uir pulse.

Source files
------------

// File: rtl/dbg_vjtag_pkg.sv
// Shared types and constants for the virtual-JTAG debug initiator.
// State encoding, default widths and slave IR codes.
package dbg_vjtag_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI,
    RESP
  } vj_state_t;

  localparam int DBG_DR_WIDTH = 38;
  localparam int DBG_IR_WIDTH = 2;

  localparam logic [DBG_IR_WIDTH-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DBG_IR_WIDTH-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [DBG_IR_WIDTH-1:0] IR_BREAK     = 2'd2;
  localparam logic [DBG_IR_WIDTH-1:0] IR_TRACECTRL = 2'd3;

endpackage

// File: rtl/dbg_vjtag_tck_gen.sv
// Divided TCK generator: low phase then high phase, TCK_DIV clks each.
// Emits a period-start pulse and a sample pulse on the last high cycle.
module dbg_vjtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic period_start,
  output logic sample
);

  localparam int CW = $clog2(2 * TCK_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * TCK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(TCK_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tck          = en && (cnt >= HALF);
  assign period_start = en && (cnt == '0);
  assign sample       = en && (cnt == LAST);

endmodule

// File: rtl/dbg_vjtag_initiator.sv
// Virtual-JTAG initiator: runs one {IR, DR} scan per command.
// Optional DBG_VJTAG_IR_CACHE_EN skips UIR when the IR is unchanged.
module dbg_vjtag_initiator
  import dbg_vjtag_pkg::*;
#(
  parameter int DR_WIDTH   = DBG_DR_WIDTH,
  parameter int IR_WIDTH   = DBG_IR_WIDTH,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BW = $clog2(DR_WIDTH);
  localparam int RW = $clog2(RTI_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);
  localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES - 1);

  vj_state_t state, state_nx;

  logic                tck_en;
  logic                period_start;
  logic                sample;
  logic                accept;
  logic                skip_uir;
  logic [IR_WIDTH-1:0] ir_lat;
  logic [IR_WIDTH-1:0] ir_hold;
  logic [DR_WIDTH-1:0] sr;
  logic [BW-1:0]       bit_cnt;
  logic [RW-1:0]       rti_cnt;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign tck_en    = (state != IDLE) && (state != RESP);
  assign rsp_dr    = sr;

  dbg_vjtag_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck (
    .clk         (clk),
    .reset       (reset),
    .en          (tck_en),
    .tck         (vji_tck),
    .period_start(period_start),
    .sample      (sample)
  );

`ifdef DBG_VJTAG_IR_CACHE_EN
  // ir_hold doubles as the cached IR; ir_vld says it reached the slave
  logic ir_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_vld <= 1'b0;
    end else if (state == UIR && period_start) begin
      ir_vld <= 1'b1;
    end
  end

  assign skip_uir = ir_vld && (cmd_ir == ir_hold);
`else
  assign skip_uir = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    vji_uir  = 1'b0;
    vji_cdr  = 1'b0;
    vji_sdr  = 1'b0;
    vji_udr  = 1'b0;
    vji_rti  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) state_nx = skip_uir ? CDR : UIR;
      end
      UIR: begin
        vji_uir = 1'b1;
        if (sample) state_nx = CDR;
      end
      CDR: begin
        vji_cdr = 1'b1;
        if (sample) state_nx = SDR;
      end
      SDR: begin
        vji_sdr = 1'b1;
        if (sample && bit_cnt == BIT_LAST) state_nx = UDR;
      end
      UDR: begin
        vji_udr = 1'b1;
        if (sample) state_nx = RTI;
      end
      RTI: begin
        vji_rti = 1'b1;
        if (sample && rti_cnt == RTI_LAST) state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // sr holds outgoing bits at the bottom and fills with TDO from the top
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_lat  <= '0;
      ir_hold <= '0;
      sr      <= '0;
      bit_cnt <= '0;
      rti_cnt <= '0;
    end else begin
      if (accept) begin
        ir_lat <= cmd_ir;
        sr     <= cmd_dr;
      end
      if (state == UIR && period_start) ir_hold <= ir_lat;
      if (state == SDR && sample) begin
        sr      <= {vji_tdo, sr[DR_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end else if (state != SDR) begin
        bit_cnt <= '0;
      end
      if (state == RTI && sample) begin
        rti_cnt <= rti_cnt + 1'b1;
      end else if (state != RTI) begin
        rti_cnt <= '0;
      end
    end
  end

  assign vji_ir_in = (state == UIR) ? ir_lat : ir_hold;
  assign vji_tdi   = (state == SDR) ? sr[0] : 1'b0;

endmodule
